// File: rtl/banked_data_array_pkg.sv
// banked_data_array_pkg: shared types and helpers for the banked cache data array.
// State encoding, even byte parity, and geometry derived from s_offset/s_index.
package banked_data_array_pkg;

   typedef enum logic {
      INIT,
      RUN
   } state_e;

   // default geometry: 32-byte lines, 8 sets
   localparam int unsigned dflt_s_offset = 5;
   localparam int unsigned dflt_s_index  = 3;

   function automatic int unsigned mask_of(input int unsigned s_offset);
      return 2 ** s_offset;
   endfunction

   function automatic int unsigned line_of(input int unsigned s_offset);
      return 8 * (2 ** s_offset);
   endfunction

   function automatic int unsigned sets_of(input int unsigned s_index);
      return 2 ** s_index;
   endfunction

   localparam int unsigned dflt_s_mask   = mask_of(dflt_s_offset);
   localparam int unsigned dflt_s_line   = line_of(dflt_s_offset);
   localparam int unsigned dflt_num_sets = sets_of(dflt_s_index);

   // even parity: stored bit makes the 9-bit total even
   function automatic logic byte_par(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/data_way.sv
// data_way: storage for one way across all sets, byte-masked write, registered
// read of one set. Optional even parity per byte (BANKED_DATA_ARRAY_PARITY_EN).
module data_way
   import banked_data_array_pkg::*;
#(
   parameter int unsigned s_offset = 5,
   parameter int unsigned s_index  = 3,
   localparam int unsigned s_mask   = mask_of(s_offset),
   localparam int unsigned s_line   = line_of(s_offset),
   localparam int unsigned num_sets = sets_of(s_index)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_en,
   input  logic [s_index-1:0] clr_idx,
   input  logic               wr_en,
   input  logic [s_index-1:0] wr_index,
   input  logic [s_mask-1:0]  wr_mask,
   input  logic [s_line-1:0]  wr_data,
   input  logic               rd_en,
   input  logic [s_index-1:0] rd_index,
`ifdef BANKED_DATA_ARRAY_PARITY_EN
   output logic [s_mask-1:0]  rd_perr,
`endif
   output logic [s_line-1:0]  rd_data
);

   logic [s_line-1:0] mem [num_sets];
   logic [s_line-1:0] rd_q;

   // storage update: clear sweep has priority, otherwise byte-masked write
   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem[clr_idx] <= '0;
      end else if (wr_en) begin
         for (int unsigned i = 0; i < s_mask; i++) begin
            if (wr_mask[i]) mem[wr_index][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   // registered read of one set; holds when no read is issued
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_q <= '0;
      else if (rd_en) rd_q <= mem[rd_index];
   end

   assign rd_data = rd_q;

`ifdef BANKED_DATA_ARRAY_PARITY_EN
   logic [s_mask-1:0] par [num_sets];
   logic [s_mask-1:0] rd_par_q;

   // parity bits follow the data bytes, including the clear sweep
   always_ff @(posedge clk) begin
      if (clr_en) begin
         par[clr_idx] <= '0;
      end else if (wr_en) begin
         for (int unsigned i = 0; i < s_mask; i++) begin
            if (wr_mask[i]) par[wr_index][i] <= byte_par(wr_data[8*i +: 8]);
         end
      end
   end

   // registered read of the parity bits alongside the data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_par_q <= '0;
      else if (rd_en) rd_par_q <= par[rd_index];
   end

   // per-byte recheck of the registered line
   always_comb begin
      rd_perr = '0;
      for (int unsigned i = 0; i < s_mask; i++) begin
         rd_perr[i] = byte_par(rd_q[8*i +: 8]) ^ rd_par_q[i];
      end
   end
`endif

endmodule

// File: rtl/banked_data_array.sv
// banked_data_array: multi-way byte-masked cache data store with registered
// read, write-first forwarding and a one-set-per-cycle clear after reset.
// Optional parity: define BANKED_DATA_ARRAY_PARITY_EN.
module banked_data_array
   import banked_data_array_pkg::*;
#(
   parameter int unsigned s_offset = 5,
   parameter int unsigned s_index  = 3,
   parameter int unsigned num_ways = 4,
   localparam int unsigned s_mask  = mask_of(s_offset),
   localparam int unsigned s_line  = line_of(s_offset),
   localparam int unsigned s_way   = (num_ways > 1) ? $clog2(num_ways) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic                         ready,
   input  logic                         rd_req,
   input  logic [s_index-1:0]           rd_index,
   output logic                         rd_valid,
   output logic [num_ways*s_line-1:0]   rd_data,
   input  logic                         wr_en,
   input  logic [s_way-1:0]             wr_way,
   input  logic [s_index-1:0]           wr_index,
   input  logic [s_mask-1:0]            wr_mask,
   input  logic [s_line-1:0]            wr_data,
   output logic [num_ways-1:0]          parity_err
);

   state_e               state;
   logic [s_index-1:0]   clr_idx;
   logic                 clr_en;
   logic                 rd_go;
   logic                 wr_go;
   logic [num_ways-1:0]  way_we;
   logic [num_ways-1:0]  fwd_hit;
   logic [s_mask-1:0]    fwd_mask;
   logic [s_line-1:0]    fwd_data;
   logic [s_line-1:0]    raw [num_ways];

   assign clr_en = (state == INIT);
   assign rd_go  = rd_req && ready;
   assign wr_go  = wr_en && ready && (32'(wr_way) < num_ways);

   // init/run control and clear-index sweep
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= INIT;
         clr_idx <= '0;
         ready   <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               clr_idx <= clr_idx + 1'b1;
               if (clr_idx == '1) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN:     ready <= 1'b1;
            default: state <= INIT;
         endcase
      end
   end

   // one-hot write enable per way; out-of-range ways never match
   always_comb begin
      way_we = '0;
      for (int unsigned w = 0; w < num_ways; w++) begin
         way_we[w] = wr_go && (32'(wr_way) == w);
      end
   end

   // The ways read before the write lands, so the write that coincides with
   // a read is captured here and merged onto the registered way data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid <= 1'b0;
         fwd_hit  <= '0;
         fwd_mask <= '0;
         fwd_data <= '0;
      end else begin
         rd_valid <= rd_go;
         if (rd_go) begin
            fwd_hit  <= (wr_index == rd_index) ? way_we : '0;
            fwd_mask <= wr_mask;
            fwd_data <= wr_data;
         end
      end
   end

`ifdef BANKED_DATA_ARRAY_PARITY_EN
   logic [s_mask-1:0] perr_b [num_ways];
`endif

   for (genvar w = 0; w < num_ways; w++) begin : g_way
      data_way #(
         .s_offset (s_offset),
         .s_index  (s_index)
      ) u_way (
         .clk      (clk),
         .rst      (rst),
         .clr_en   (clr_en),
         .clr_idx  (clr_idx),
         .wr_en    (way_we[w]),
         .wr_index (wr_index),
         .wr_mask  (wr_mask),
         .wr_data  (wr_data),
         .rd_en    (rd_go),
         .rd_index (rd_index),
`ifdef BANKED_DATA_ARRAY_PARITY_EN
         .rd_perr  (perr_b[w]),
`endif
         .rd_data  (raw[w])
      );
   end

   // forwarding mux: forwarded bytes replace the stored bytes of the hit way
   always_comb begin
      rd_data = '0;
      for (int unsigned w = 0; w < num_ways; w++) begin
         for (int unsigned i = 0; i < s_mask; i++) begin
            rd_data[w*s_line + 8*i +: 8] = (fwd_hit[w] && fwd_mask[i]) ?
                                           fwd_data[8*i +: 8] : raw[w][8*i +: 8];
         end
      end
   end

`ifdef BANKED_DATA_ARRAY_PARITY_EN
   // forwarded bytes carry fresh parity, so their stored check is masked off
   always_comb begin
      parity_err = '0;
      for (int unsigned w = 0; w < num_ways; w++) begin
         parity_err[w] = |(perr_b[w] & ~(fwd_hit[w] ? fwd_mask : {s_mask{1'b0}}));
      end
   end
`else
   assign parity_err = '0;
`endif

endmodule

// File: tb/tb_banked_data_array.sv
// tb_banked_data_array: directed checks of banked_data_array (4 ways, 8 sets,
// 32-byte lines). Parity section active with BANKED_DATA_ARRAY_PARITY_EN.
module tb_banked_data_array;

   localparam int unsigned NW = 4;
   localparam int unsigned LW = 256;

   logic            clk = 1'b0;
   logic            rst;
   logic            ready;
   logic            rd_req;
   logic [2:0]      rd_index;
   logic            rd_valid;
   logic [NW*LW-1:0] rd_data;
   logic            wr_en;
   logic [1:0]      wr_way;
   logic [2:0]      wr_index;
   logic [31:0]     wr_mask;
   logic [LW-1:0]   wr_data;
   logic [NW-1:0]   parity_err;

   int n_checks = 0;
   int n_fail   = 0;
   logic [NW*LW-1:0] e;

   banked_data_array #(
      .s_offset (5),
      .s_index  (3),
      .num_ways (NW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ready      (ready),
      .rd_req     (rd_req),
      .rd_index   (rd_index),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .wr_en      (wr_en),
      .wr_way     (wr_way),
      .wr_index   (wr_index),
      .wr_mask    (wr_mask),
      .wr_data    (wr_data),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_line(input string tag, input logic [NW*LW-1:0] exp);
      for (int w = 0; w < NW; w++)
         chk($sformatf("%s_w%0d", tag, w), rd_data[w*LW +: LW], exp[w*LW +: LW]);
      chk({tag, "_perr"}, LW'(parity_err), '0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // counts the clear sweep edge by edge; ready must rise only after the 8th
   task automatic init_seq(input string tag);
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("%s_ready%0d", tag, k), LW'(ready), LW'(k == 8));
         chk($sformatf("%s_rdv%0d", tag, k), LW'(rd_valid), '0);
      end
   endtask

   task automatic rd(input logic [2:0] idx);
      rd_req = 1'b1; rd_index = idx;
      tick();
      rd_req = 1'b0;
      chk($sformatf("rdv_set%0d", idx), LW'(rd_valid), 1);
   endtask

   initial begin
      rst = 1'b0; rd_req = 1'b0; rd_index = '0; wr_en = 1'b0;
      wr_way = '0; wr_index = '0; wr_mask = '0; wr_data = '0;
      #22;
      chk("rst_ready", LW'(ready), '0);
      chk("rst_rdv", LW'(rd_valid), '0);
      chk_line("rst_data", '0);

      // requests during INIT must be ignored
      @(negedge clk);
      rst = 1'b1;
      rd_req = 1'b1; rd_index = 3'd2;
      wr_en = 1'b1; wr_way = 2'd0; wr_index = 3'd2; wr_mask = '1; wr_data = '1;
      init_seq("init1");
      rd_req = 1'b0; wr_en = 1'b0;

      // every set reads back zero, valid one cycle after each request
      for (int s = 0; s < 8; s++) begin
         rd(3'(s));
         chk_line($sformatf("clr_set%0d", s), '0);
      end
      tick();
      chk("rdv_idle", LW'(rd_valid), '0);

      // masked write of low 4 bytes
      wr_en = 1'b1; wr_way = 2'd2; wr_index = 3'd5; wr_mask = 32'h0000_000F;
      wr_data = {{224{1'b1}}, 32'hDDCC_BBAA};
      tick();
      wr_en = 1'b0;
      rd(3'd5);
      e = '0; e[2*LW +: 32] = 32'hDDCC_BBAA;
      chk_line("wr_set5", e);

      // same-cycle write/read, same set: write-first
      wr_en = 1'b1; wr_way = 2'd1; wr_index = 3'd3; wr_mask = 32'h1; wr_data = 256'h55;
      rd(3'd3);
      wr_en = 1'b0;
      e = '0; e[LW +: 8] = 8'h55;
      chk_line("fwd_set3", e);
      tick();
      chk("hold_rdv", LW'(rd_valid), '0);
      chk_line("hold_set3", e);
      rd(3'd3);
      chk_line("stored_set3", e);

      // forwarding merges new byte 1 with old bytes of way 2
      wr_en = 1'b1; wr_way = 2'd2; wr_index = 3'd5; wr_mask = 32'h2; wr_data = 256'h7700;
      rd(3'd5);
      wr_en = 1'b0;
      e = '0; e[2*LW +: 32] = 32'hDDCC_77AA;
      chk_line("merge_set5", e);

      // back-to-back reads with writes to set 7 interleaved
      for (int k = 0; k < 3; k++) begin
         wr_en = 1'b1; wr_index = 3'd7;
         case (k)
            0: begin wr_way = 2'd0; wr_mask = 32'h1;         wr_data = 256'h11; end
            1: begin wr_way = 2'd3; wr_mask = 32'h8000_0000; wr_data = {8'h99, 248'h0}; end
            default: begin wr_way = 2'd1; wr_mask = 32'h3;   wr_data = 256'h2233; end
         endcase
         rd_req = 1'b1; rd_index = 3'(k);
         tick();
         chk($sformatf("b2b_rdv%0d", k), LW'(rd_valid), 1);
         chk_line($sformatf("b2b_set%0d", k), '0);
      end
      rd_req = 1'b0; wr_en = 1'b0;
      rd(3'd7);
      e = '0; e[7:0] = 8'h11; e[LW +: 16] = 16'h2233; e[3*LW + 248 +: 8] = 8'h99;
      chk_line("set7", e);

      // empty mask is a no-op, also on the forwarding path
      wr_en = 1'b1; wr_way = 2'd0; wr_index = 3'd7; wr_mask = '0; wr_data = '1;
      rd(3'd7);
      wr_en = 1'b0;
      chk_line("mask0_fwd", e);
      rd(3'd7);
      chk_line("mask0_set7", e);

      // reset mid-RUN with a read pending
      rd_req = 1'b1; rd_index = 3'd7;
      tick();
      chk("pre_rst_rdv", LW'(rd_valid), 1);
      #2 rst = 1'b0;
      #1;
      chk("run_rst_ready", LW'(ready), '0);
      chk("run_rst_rdv", LW'(rd_valid), '0);
      chk_line("run_rst_data", '0);
      @(negedge clk);
      rst = 1'b1;

      // reset again mid-INIT, then a full sweep must follow
      for (int k = 0; k < 3; k++) tick();
      chk("mid_init_ready", LW'(ready), '0);
      #2 rst = 1'b0;
      #1;
      chk("init_rst_ready", LW'(ready), '0);
      chk("init_rst_rdv", LW'(rd_valid), '0);
      @(negedge clk);
      rst = 1'b1;
      init_seq("init2");
      rd_req = 1'b0;
      rd(3'd7);
      chk_line("post_rst_set7", '0);
      rd(3'd5);
      chk_line("post_rst_set5", '0);
      rd(3'd3);
      chk_line("post_rst_set3", '0);

`ifdef BANKED_DATA_ARRAY_PARITY_EN
      rd(3'd0);
      chk_line("par_clean", '0);
      dut.g_way[3].u_way.par[0][4] = ~dut.g_way[3].u_way.par[0][4];
      rd(3'd0);
      chk("par_flip", LW'(parity_err), LW'(4'b1000));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/banked_data_array.md
# banked_data_array

Multi-way, byte-masked cache data store with a registered read port, write-first forwarding, and a sequential post-reset clear engine. It sits between the cache control FSM and the bus adapter and holds the data lines of all ways of a set-associative cache. One read request returns all ways of a set so way selection happens after the tag compare. It replaces flash-reset storage with a one-set-per-cycle clear, so the array maps to block RAM.

## Interface
Parameters:
- s_offset, 5, log2 bytes per line; s_mask = 2**s_offset, s_line = 8*s_mask
- s_index, 3, log2 sets; num_sets = 2**s_index
- num_ways, 4, ways per set (≥1); s_way = $clog2(num_ways), minimum 1

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- ready  out  1  array accepts reads/writes
- rd_req  in  1  read request, sampled when ready
- rd_index  in  s_index  set to read
- rd_valid  out  1  rd_data/parity_err valid this cycle
- rd_data  out  num_ways*s_line  way w at [w*s_line +: s_line]
- wr_en  in  1  write request, sampled when ready
- wr_way  in  s_way  binary way select
- wr_index  in  s_index  set to write
- wr_mask  in  s_mask  byte enables, bit i → byte i
- wr_data  in  s_line  write data
- parity_err  out  num_ways  per-way parity fault on last read

## Operation
- FSM states: INIT, RUN. Asserting rst forces INIT, clr_idx=0, ready=0, rd_valid=0, rd_data=0, parity_err=0, regardless of operation in flight.
- INIT: each cycle zeroes all ways of set clr_idx (parity bits to match); clr_idx increments; on clr_idx==num_sets-1 go RUN. rd_req/wr_en ignored (no rd_valid, no write).
- RUN: ready=1; never leaves RUN except via reset.
- Write: wr_en && ready → for each i with wr_mask[i], byte i of way wr_way, set wr_index ← wr_data byte i; other bytes unchanged. wr_mask=0 is a no-op.
- Read: rd_req && ready → next cycle rd_valid=1, rd_data = all ways of rd_index.
- Same-cycle read and write to the same index: write-first; returned way wr_way shows the merged line (new bytes where masked, old elsewhere); other ways unaffected.
- Same-cycle read/write different index: independent.
- No rd_req: rd_valid=0 next cycle, rd_data and parity_err hold last value.
- wr_way ≥ num_ways (non-power-of-two ways): write dropped.

## Timing
- Reset release to ready=1: exactly num_sets rising edges (ready is high after the num_sets-th edge).
- Read latency: 1 cycle, fully pipelined, one read per cycle.
- Write visible to a read issued the same cycle (forwarding) and to all later reads.
- All outputs registered; no combinational input→output path.

## Configuration
- BANKED_DATA_ARRAY_PARITY_EN defined: one even-parity bit stored per byte per way, written with each byte (including the INIT clear). On read, parity recomputed; parity_err[w]=1 alongside rd_valid if any byte of way w mismatches. Forwarded bytes use freshly computed parity (never flag).
- Not defined: no parity storage; parity_err tied to 0; port list unchanged.

## Structure
- Package banked_data_array_pkg: state enum (INIT, RUN), a function for even byte parity, and shared localparams derived from s_offset/s_index (s_mask, s_line, num_sets).
- Sub-module data_way: one way's storage for all sets, byte-masked write, registered read of one set, optional parity bits and check; banked_data_array instantiates num_ways of them plus the FSM, clear counter and forwarding mux.

## Test plan
- Reset, release: ready=0 for 8 cycles (s_index=3), then 1; read every set → rd_data all zero, rd_valid one cycle after each rd_req.
- Write way 2, set 5, mask 0x0000000F, data 0x...DDCCBBAA; read set 5 → way 2 bytes 0–3 = AA BB CC DD, rest 0; other ways 0.
- Same-cycle write way 1 set 3 mask 0x1 data 0x55 with read set 3 → next cycle way 1 byte 0 = 0x55.
- Back-to-back reads sets 0,1,2 with writes to set 7 interleaved → rd_valid=1 three consecutive cycles, data correct, set 7 updated.
- Assert rst mid-INIT and mid-RUN with rd_req pending → rd_valid=0, ready=0 immediately, full 8-cycle INIT restarts, prior data reads back zero.
- With BANKED_DATA_ARRAY_PARITY_EN: normal reads → parity_err=0; bench flips stored parity bit of way 3 set 0 byte 4 → read set 0 gives parity_err=4'b1000.
